// File: rtl/map_rom_arb_pkg.sv
// Shared definitions for the map/sprite ROM arbiter.
//   - ADDR_W_DEF / DATA_W_DEF : default ROM address / data widths
//   - ROM_LAT                 : ROM read latency in cycles (synchronous read)
//   - tag_t                   : response tag {valid, is_pix, idx} carried
//                               alongside each read until its data returns
//   - idx_width()             : width of a client index for n clients
package map_rom_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 19;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ROM_LAT    = 1;

    // The tag index is sized for the largest supported client count (8).
    localparam int unsigned IDX_W_MAX  = 3;

    typedef struct packed {
        logic                 valid;
        logic                 is_pix;
        logic [IDX_W_MAX-1:0] idx;
    } tag_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/map_rom_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Ports:
//   eligible   in  NUM_REQ  requesters allowed to win this cycle
//   ptr        in  IDX_W    index of the last granted requester
//   win_onehot out NUM_REQ  one-hot winner (zero when none eligible)
//   win_idx    out IDX_W    winner index
//   any_valid  out 1        at least one requester is eligible
// The search starts at ptr+1 and wraps modulo NUM_REQ, so NUM_REQ need not
// be a power of two.
module rr_picker
    import map_rom_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win_onehot,
    output logic [IDX_W-1:0]   win_idx,
    output logic               any_valid
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        win_onehot = '0;
        win_idx    = '0;
        any_valid  = 1'b0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr) + k) % NUM_REQ);
            if (!any_valid && eligible[cand]) begin
                any_valid = 1'b1;
                win_idx   = cand;
            end
        end
        if (any_valid) begin
            win_onehot = NUM_REQ'(1) << win_idx;
        end
    end

endmodule

// File: rtl/map_rom_arbiter.sv
// Arbiter sharing the single-port synchronous-read map/sprite ROM between
// the colour mapper pixel fetch (highest priority) and NUM_REQ round-robin
// movement/collision clients.
// Ports:
//   Clk, Reset           clock and synchronous active-high reset
//   pix_req/pix_addr     single-cycle pixel fetch request
//   pix_valid/pix_data   pixel data, 2 cycles after an accepted pix_req
//   pix_miss             pixel fetch dropped by starvation preemption
//   req/req_addr         client requests (held until granted) and addresses
//   gnt                  registered one-hot grant pulse
//   rsp_valid/rsp_data   one-hot client response valid and data
//   rom_rd/rom_addr      registered ROM read strobe and address
//   rom_data             ROM data, valid one cycle after rom_rd
// Optional feature macro: ROM_ARB_STARVE_EN enables the starvation counter
// that lets a waiting client preempt the pixel port after STARVE_MAX cycles.
module map_rom_arbiter
    import map_rom_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 64
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      pix_req,
    input  logic [ADDR_W-1:0]         pix_addr,
    output logic                      pix_valid,
    output logic                      pix_miss,
    output logic [DATA_W-1:0]         pix_data,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rom_rd,
    output logic [ADDR_W-1:0]         rom_addr,
    input  logic [DATA_W-1:0]         rom_data
);

    localparam int unsigned IDX_W = idx_width(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("map_rom_arbiter: NUM_REQ must be 2..8");
    end
    if (STARVE_MAX < 1) begin : g_bad_starve_max
        $error("map_rom_arbiter: STARVE_MAX must be at least 1");
    end
    if (ROM_LAT != 1) begin : g_bad_rom_lat
        $error("map_rom_arbiter: tag pipeline assumes a 1-cycle ROM");
    end

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] win_onehot;
    logic [IDX_W-1:0]   win_idx;
    logic               any_elig;
    logic               preempt;
    logic               pix_win;
    logic               cli_win;

    logic [NUM_REQ-1:0] gnt_d, gnt_q;
    logic               rom_rd_d, rom_rd_q;
    logic [ADDR_W-1:0]  rom_addr_d, rom_addr_q;
    logic [IDX_W-1:0]   ptr_d, ptr_q;
    tag_t               tag1_d, tag1_q;
    tag_t               tag2_d, tag2_q;

`ifdef ROM_ARB_STARVE_EN
    localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_d, starve_q;
    logic                miss1_d, miss1_q;
    logic                miss2_d, miss2_q;
`endif

    // A client that holds gnt this cycle is masked so a still-high req is
    // not granted twice for the same transaction.
    assign elig = req & ~gnt_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .eligible   (elig),
        .ptr        (ptr_q),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .any_valid  (any_elig)
    );

    always_comb begin
`ifdef ROM_ARB_STARVE_EN
        preempt = any_elig && (32'(starve_q) == STARVE_MAX);
`else
        preempt = 1'b0;
`endif
        pix_win = pix_req && !preempt;
        cli_win = any_elig && !pix_win;

        gnt_d      = cli_win ? win_onehot : '0;
        rom_rd_d   = pix_win || cli_win;
        rom_addr_d = rom_addr_q;
        if (pix_win) begin
            rom_addr_d = pix_addr;
        end else if (cli_win) begin
            rom_addr_d = req_addr[win_idx*ADDR_W +: ADDR_W];
        end
        ptr_d = cli_win ? win_idx : ptr_q;

        tag1_d        = '0;
        tag1_d.valid  = rom_rd_d;
        tag1_d.is_pix = pix_win;
        tag1_d.idx    = IDX_W_MAX'(win_idx);
        tag2_d        = tag1_q;

`ifdef ROM_ARB_STARVE_EN
        miss1_d = pix_req && preempt;
        miss2_d = miss1_q;
        // Counting only happens while a client waits behind the pixel port.
        if (cli_win || !any_elig) begin
            starve_d = '0;
        end else begin
            starve_d = starve_q + STARVE_W'(1);
        end
`endif
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            gnt_q      <= '0;
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);
            tag1_q     <= '0;
            tag2_q     <= '0;
`ifdef ROM_ARB_STARVE_EN
            starve_q   <= '0;
            miss1_q    <= 1'b0;
            miss2_q    <= 1'b0;
`endif
        end else begin
            gnt_q      <= gnt_d;
            rom_rd_q   <= rom_rd_d;
            rom_addr_q <= rom_addr_d;
            ptr_q      <= ptr_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag2_d;
`ifdef ROM_ARB_STARVE_EN
            starve_q   <= starve_d;
            miss1_q    <= miss1_d;
            miss2_q    <= miss2_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign rom_rd    = rom_rd_q;
    assign rom_addr  = rom_addr_q;
    assign pix_data  = rom_data;
    assign rsp_data  = rom_data;
    assign pix_valid = tag2_q.valid && tag2_q.is_pix;
    assign rsp_valid = (tag2_q.valid && !tag2_q.is_pix)
                       ? (NUM_REQ'(1) << tag2_q.idx) : '0;
`ifdef ROM_ARB_STARVE_EN
    assign pix_miss  = miss2_q;
`else
    assign pix_miss  = 1'b0;
`endif

endmodule

// File: tb/tb_map_rom_arbiter.sv
// Directed bench for map_rom_arbiter with a scoreboard of expected ROM
// issues (rom_rd/rom_addr/gnt) and responses (valid/miss/data).
module tb_map_rom_arbiter;

    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned STARVE_MAX = 4;

    logic                      clk = 1'b0;
    logic                      Reset = 1'b1;
    logic                      pix_req = 1'b0;
    logic [ADDR_W-1:0]         pix_addr = '0;
    logic                      pix_valid, pix_miss;
    logic [DATA_W-1:0]         pix_data, rsp_data;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
    logic [NUM_REQ-1:0]        gnt, rsp_valid;
    logic                      rom_rd;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data = '0;

    int unsigned cyc = 0;
    int errors = 0;
    int checks = 0;

    map_rom_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .Clk       (clk),
        .Reset     (Reset),
        .pix_req   (pix_req),
        .pix_addr  (pix_addr),
        .pix_valid (pix_valid),
        .pix_miss  (pix_miss),
        .pix_data  (pix_data),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_rd    (rom_rd),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ a[15:8] ^ {a[18:16], 5'b0} ^ 8'hA5;
    endfunction

    // Synchronous-read ROM model.
    always @(posedge clk) if (rom_rd) rom_data <= rom_fn(rom_addr);

    typedef struct {
        int unsigned        due;
        logic [NUM_REQ-1:0] g;
        logic [ADDR_W-1:0]  addr;
    } issue_t;

    typedef struct {
        int unsigned        due;
        logic               pix;
        logic [NUM_REQ-1:0] rsp;
        logic               miss;
        logic [ADDR_W-1:0]  addr;
    } resp_t;

    issue_t iss_q[$];
    resp_t  rsp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push_issue(input logic [NUM_REQ-1:0] g, input logic [ADDR_W-1:0] a);
        issue_t e;
        e.due = cyc + 1; e.g = g; e.addr = a;
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input logic p, input logic [NUM_REQ-1:0] r,
                            input logic m, input logic [ADDR_W-1:0] a);
        resp_t e;
        e.due = cyc + 2; e.pix = p; e.rsp = r; e.miss = m; e.addr = a;
        rsp_q.push_back(e);
    endtask

    task automatic push_pix(input logic [ADDR_W-1:0] a);
        push_issue('0, a);
        push_rsp(1'b1, '0, 1'b0, a);
    endtask

    task automatic push_cli(input int unsigned i, input logic m);
        logic [ADDR_W-1:0] a;
        a = req_addr[i*ADDR_W +: ADDR_W];
        push_issue(NUM_REQ'(1) << i, a);
        push_rsp(1'b0, NUM_REQ'(1) << i, m, a);
    endtask

    task automatic mon();
        issue_t e;
        resp_t  r;
        if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
            e = iss_q.pop_front();
            check("rom_rd", 32'(rom_rd), 32'd1);
            check("rom_addr", 32'(rom_addr), 32'(e.addr));
            check("gnt", 32'(gnt), 32'(e.g));
        end else begin
            check("rom_rd_idle", 32'(rom_rd), 32'd0);
            check("gnt_idle", 32'(gnt), 32'd0);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            check("pix_valid", 32'(pix_valid), 32'(r.pix));
            check("rsp_valid", 32'(rsp_valid), 32'(r.rsp));
            check("pix_miss", 32'(pix_miss), 32'(r.miss));
            if (r.pix) check("pix_data", 32'(pix_data), 32'(rom_fn(r.addr)));
            if (r.rsp != '0) check("rsp_data", 32'(rsp_data), 32'(rom_fn(r.addr)));
        end else begin
            check("pix_valid_idle", 32'(pix_valid), 32'd0);
            check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
            check("pix_miss_idle", 32'(pix_miss), 32'd0);
        end
    endtask

    // Inputs are driven just after a rising edge; outputs checked at the
    // following falling edge, then time advances to the next cycle.
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; req = '0; pix_req = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < int'(NUM_REQ); i++)
            req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(32'h00020 + i * 32'h111);

        // Reset state: first edge with Reset high, then outputs checked idle.
        @(posedge clk); #1;
        tick();
        Reset = 1'b0;
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        repeat (2) tick();

        // Single client request.
        req_addr[0 +: ADDR_W] = ADDR_W'(32'h00010);
        req = 4'b0001; push_cli(0, 1'b0); tick();
        req = 4'b0000; repeat (3) tick();

        // All clients held: round-robin 0,1,2,3,0 from the reset pointer.
        do_reset();
        req = 4'b1111;
        push_cli(0, 1'b0); tick();
        push_cli(1, 1'b0); tick();
        push_cli(2, 1'b0); tick();
        push_cli(3, 1'b0); tick();
        push_cli(0, 1'b0); tick();
        req = 4'b0000; repeat (3) tick();

        // Back-to-back pixel stream.
        for (int k = 0; k < 16; k++) begin
            pix_req = 1'b1; pix_addr = ADDR_W'(32'h100 + k);
            push_pix(pix_addr); tick();
        end
        pix_req = 1'b0; repeat (3) tick();

        // Pixel and client in the same cycle: pixel first.
        pix_req = 1'b1; pix_addr = ADDR_W'(32'h150); req = 4'b0100;
        push_pix(pix_addr); tick();
        pix_req = 1'b0; push_cli(2, 1'b0); tick();
        req = 4'b0000; repeat (3) tick();

        // A lone held client is granted every other cycle.
        req = 4'b0100;
        push_cli(2, 1'b0); tick();
        tick();
        push_cli(2, 1'b0); tick();
        tick();
        req = 4'b0000; repeat (3) tick();

        // Pixel pressure with client 1 waiting.
        do_reset();
        req = 4'b0010;
`ifdef ROM_ARB_STARVE_EN
        for (int k = 0; k < int'(STARVE_MAX); k++) begin
            pix_req = 1'b1; pix_addr = ADDR_W'(32'h300 + k);
            push_pix(pix_addr); tick();
        end
        pix_req = 1'b1; pix_addr = ADDR_W'(32'h3FF);
        push_cli(1, 1'b1); tick();
        pix_req = 1'b0; req = 4'b0000;
`else
        for (int k = 0; k < 8; k++) begin
            pix_req = 1'b1; pix_addr = ADDR_W'(32'h300 + k);
            push_pix(pix_addr); tick();
        end
        pix_req = 1'b0;
        push_cli(1, 1'b0); tick();
        req = 4'b0000;
`endif
        repeat (3) tick();

        // Reset during a grant cycle squashes the in-flight response and
        // restores the pointer (client 0 before client 3).
        req = 4'b1000;
        push_issue(4'b1000, req_addr[3*ADDR_W +: ADDR_W]); tick();
        req = 4'b0000; Reset = 1'b1; tick();
        Reset = 1'b0; req = 4'b1001;
        push_cli(0, 1'b0); tick();
        push_cli(3, 1'b0); tick();
        req = 4'b0000; repeat (4) tick();

        check("sb_issue_empty", 32'(iss_q.size()), 32'd0);
        check("sb_rsp_empty", 32'(rsp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/map_rom_arbiter.md
# map_rom_arbiter

Shares the single-port, synchronous-read map/sprite ROM among several requesters. The highest-priority requester is the colour mapper's per-pixel fetch. The others are NUM_REQ movement/collision clients (Pac-Man, ghosts), served round-robin. The block sits between the colour mapper, the movement modules and the ROM, replacing direct ROM address muxing.

## Interface
Parameters:
- NUM_REQ, 4, number of round-robin clients (2..8, need not be a power of 2)
- ADDR_W, 19, ROM address width
- DATA_W, 8, ROM data width
- STARVE_MAX, 64, consecutive pixel-won cycles before a pending client preempts the pixel port (used only with ROM_ARB_STARVE_EN)

Ports:
- Clk  in  1  system clock (MAX10_CLK1_50 domain); one clock, everything rising-edge
- Reset  in  1  synchronous, active-high
- pix_req  in  1  pixel fetch request, single-cycle, no handshake
- pix_addr  in  ADDR_W  pixel fetch address
- pix_valid  out  1  pixel data valid, exactly 2 cycles after an accepted pix_req
- pix_miss  out  1  pixel fetch dropped (starvation preemption), in the slot where pix_valid would be
- pix_data  out  DATA_W  pixel read data (rom_data passthrough)
- req  in  NUM_REQ  client request, held until granted
- req_addr  in  NUM_REQ*ADDR_W  client addresses, client i at [i*ADDR_W +: ADDR_W], held with req
- gnt  out  NUM_REQ  one-hot grant pulse, registered
- rsp_valid  out  NUM_REQ  one-hot response valid
- rsp_data  out  DATA_W  client read data (rom_data passthrough)
- rom_rd  out  1  ROM read strobe, registered
- rom_addr  out  ADDR_W  ROM address, registered
- rom_data  in  DATA_W  ROM data, valid 1 cycle after rom_rd

## Operation
- Each cycle N the arbiter picks at most one winner.
  - Default: pix_req wins.
  - Otherwise the round-robin winner among eligible req bits wins.
- Eligibility: req[i]=1 and gnt[i]=0 in cycle N. The client sees its gnt at the edge, so a req still high in the grant cycle is not double-granted.
- Round-robin: a pointer holds the index of the last granted client. The search starts at pointer+1 modulo NUM_REQ. The pointer updates only on a client grant. Pixel grants do not move it.
- Winner effects at edge N→N+1:
  - rom_rd=1 and rom_addr=winner address.
  - For a client winner, gnt[i]=1 for exactly one cycle.
- A 2-stage tag pipeline carries {pixel, client index, valid}.
  - At N+2 the tag asserts pix_valid or rsp_valid[i].
  - pix_data and rsp_data both equal rom_data combinationally. They are qualified only by their valid.
- No winner in cycle N: rom_rd=0 at N+1. rom_addr holds its last value.
- Clients need not drop req after gnt. If req stays high, the next request becomes eligible the cycle after gnt.

## Timing
- Reset values: gnt=0, rsp_valid=0, pix_valid=0, pix_miss=0, rom_rd=0, rom_addr=0, RR pointer=NUM_REQ-1 (client 0 first), starve counter=0.
- Latency: request cycle N → gnt/rom_rd at N+1 → data valid at N+2. Throughput is one read per cycle.
- Reset asserted mid-operation clears the tag pipeline. No pix_valid or rsp_valid appears in the two cycles after Reset deasserts for reads issued before it.
- Simultaneous pix_req and all clients: the pixel wins (starvation path excepted). Clients are served in RR order once pixel requests stop.
- A single requesting client is granted every other cycle at most, because of the gnt-masking rule.

## Configuration
- Macro: ROM_ARB_STARVE_EN.
- Defined:
  - The starve counter increments each cycle in which a client is eligible but the pixel wins.
  - The counter clears on any client grant or when no client is eligible.
  - When the count equals STARVE_MAX, the RR winner takes the next cycle even if pix_req=1. That pix_req is dropped, and pix_miss pulses at N+2.
- Undefined: the pixel always wins, pix_miss is tied 0, and no counter exists.

## Structure
- Package map_rom_arb_pkg:
  - ADDR_W/DATA_W defaults
  - ROM_LAT=1 constant
  - typedef for the tag struct {valid, is_pix, idx}
  - function clog2-based index width
- Sub-module rr_picker: combinational round-robin select. Inputs: eligible vector and pointer. Outputs: one-hot winner and index, plus any_valid. It is instantiated once.

## Test plan
- Reset, then idle: all outputs 0. Assert req[0]=1 with addr 0x00010 → gnt[0] the next cycle, rom_addr=0x00010, rsp_valid[0] one cycle later with rsp_data=ROM[0x00010].
- req=4'b1111 held, no pixel traffic → grants in order 0,1,2,3,0; the pointer wraps from 3 to 0.
- pix_req every cycle, addrs 0x100..0x10F → pix_valid at fixed 2-cycle offset with matching data and no gaps; rom_rd continuously 1.
- pix_req and req[2] in the same cycle → pixel granted first, gnt[2] one cycle later; both responses correct and ordered.
- With ROM_ARB_STARVE_EN, STARVE_MAX=4, pix_req constant, req[1] held → gnt[1] on the 5th cycle, pix_miss=1 exactly once two cycles later. Without the macro, gnt[1] never asserts.
- Reset pulsed one cycle after a client grant → no rsp_valid follows; the next req[3] is granted as if from the reset state.
